// File: rtl/pdm_mic_decimator.sv
// PDM microphone front end: drives the mic clock, captures the 1-bit stream,
// boxcar-decimates by ones-counting, optionally removes DC, applies gain and
// saturates to 8-bit signed PCM with a one-cycle valid strobe.
module pdm_mic_decimator #(
    parameter int CLK_DIV    = 32,
    parameter int DECIM      = 256,
    parameter int DC_SHIFT   = 0,
    parameter int GAIN_SHIFT = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic       pdm_data_in,
    output logic       mic_clk_out,
    output logic [7:0] audio_out,
    output logic       audio_valid_out
);
    localparam int HALF = CLK_DIV / 2;
    localparam int DIVW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int LD   = $clog2(DECIM);
    localparam int RW   = LD + 1;   // raw sample width, holds -DECIM/2..+DECIM/2
    localparam int XW   = RW + 9;   // DC math: raw<<8 plus one guard bit for the difference
    localparam int GW   = XW + 4;   // room for the largest gain shift
    localparam logic signed [GW-1:0] SAT_HI = GW'(127);
    localparam logic signed [GW-1:0] SAT_LO = GW'(-128);

    logic [1:0]           sync;
    logic                 pdm_sync;
    logic [DIVW-1:0]      div;
    logic                 tc;
    logic                 cap;
    logic                 capture;
    logic [LD-1:0]        bit_cnt;
    logic [RW-1:0]        ones_cnt;
    logic                 last;
    logic signed [RW-1:0] raw_next;
    logic signed [RW-1:0] s1_raw;
    logic                 s1_vld;
    logic signed [XW-1:0] raw_ext;
    logic signed [XW-1:0] raw_fx;
    logic signed [XW-1:0] dc;
    logic signed [XW-1:0] dc_step;
    logic signed [XW-1:0] dc_next;
    logic signed [XW-1:0] hp_next;
    logic signed [XW-1:0] hp;
    logic                 s2_vld;
    logic signed [GW-1:0] g;
    logic [7:0]           sample_next;

    assign pdm_sync = sync[1];
    assign tc       = (div == DIVW'(HALF - 1));
    // cap marks the cycle in which mic_clk_out has just gone high
    assign capture  = cap && enable_in;
    assign last     = &bit_cnt;
    assign raw_next = $signed(ones_cnt + RW'(pdm_sync) - RW'(DECIM / 2));

    // Two-flop synchronizer for the asynchronous mic data
    always_ff @(posedge clk_in) begin
        if (rst_in) sync <= 2'b00;
        else        sync <= {sync[0], pdm_data_in};
    end

    // Mic clock divider; disabling parks the clock low and restarts the phase
    always_ff @(posedge clk_in) begin
        if (rst_in || !enable_in) begin
            div         <= '0;
            mic_clk_out <= 1'b0;
            cap         <= 1'b0;
        end else begin
            cap <= tc && !mic_clk_out;
            if (tc) begin
                div         <= '0;
                mic_clk_out <= ~mic_clk_out;
            end else begin
                div <= div + DIVW'(1);
            end
        end
    end

    // Decimation window: count captured bits and ones; partial windows are dropped on disable
    always_ff @(posedge clk_in) begin
        if (rst_in || !enable_in) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (capture) begin
            if (last) begin
                bit_cnt  <= '0;
                ones_cnt <= '0;
            end else begin
                bit_cnt  <= bit_cnt + LD'(1);
                ones_cnt <= ones_cnt + RW'(pdm_sync);
            end
        end
    end

    // S1: register the centred window count
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_vld <= 1'b0;
            s1_raw <= '0;
        end else begin
            s1_vld <= capture && last;
            if (capture && last) s1_raw <= raw_next;
        end
    end

    // DC tracker: dc holds raw with 8 fractional bits; hp uses the pre-update dc
    always_comb begin
        raw_ext = $signed({{9{s1_raw[RW-1]}}, s1_raw});
        raw_fx  = raw_ext <<< 8;
        dc_step = (raw_fx - dc) >>> DC_SHIFT;
        hp_next = raw_ext;
        dc_next = dc;
        if (DC_SHIFT != 0) begin
            hp_next = raw_ext - (dc >>> 8);
            dc_next = dc + dc_step;
        end
    end

    // S2: DC removal stage
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_vld <= 1'b0;
            hp     <= '0;
            dc     <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                hp <= hp_next;
                dc <= dc_next;
            end
        end
    end

    // Gain in a width that cannot overflow, then clamp to 8-bit signed
    always_comb begin
        g = $signed({{4{hp[XW-1]}}, hp}) <<< GAIN_SHIFT;
        if (g > SAT_HI)      sample_next = 8'h7f;
        else if (g < SAT_LO) sample_next = 8'h80;
        else                 sample_next = g[7:0];
    end

    // S3: output register and strobe; audio_out holds between strobes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            audio_valid_out <= 1'b0;
            audio_out       <= '0;
        end else begin
            audio_valid_out <= s2_vld;
            if (s2_vld) audio_out <= sample_next;
        end
    end
endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Scoreboard bench: the stimulus process drives a mic model and pushes expected
// samples (value and due cycle); monitors pop and compare on every strobe.
module tb_pdm_mic_decimator;
    localparam int CLK_DIV = 32;
    localparam int DECIM   = 256;
    localparam int HALF    = CLK_DIV / 2;
    localparam int LAT     = HALF + (DECIM - 1) * CLK_DIV + 3;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       enable_in = 1'b0;
    logic       pdm_data_in = 1'b0;
    logic       mic_a, mic_g, va, vg;
    logic [7:0] aa, ag;

    exp_t qa[$];
    exp_t qg[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   held_a = 0, held_g = 0, last_strobe = -1;
    int   run = 0, nb = 0, ones = 0, dc_g = 0, start = 0;
    bit   win_done = 1'b0, prev_rst = 1'b0;
    bit   pat[DECIM];

    always #5 clk = ~clk;

    pdm_mic_decimator dut_a (
        .clk_in(clk), .rst_in(rst_in), .enable_in(enable_in), .pdm_data_in(pdm_data_in),
        .mic_clk_out(mic_a), .audio_out(aa), .audio_valid_out(va)
    );

    pdm_mic_decimator #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .DC_SHIFT(4), .GAIN_SHIFT(2)) dut_g (
        .clk_in(clk), .rst_in(rst_in), .enable_in(enable_in), .pdm_data_in(pdm_data_in),
        .mic_clk_out(mic_g), .audio_out(ag), .audio_valid_out(vg)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int fdiv(input int a, input int s);
        int d;
        d = 1 << s;
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int sat8(input int x);
        if (x > 127)  return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    // 0: all zero, 1: all one, 2: alternating, 3: exactly 160 ones shuffled, 4: random
    task automatic gen_pattern(input int mode);
        bit t;
        int j;
        for (int i = 0; i < DECIM; i++) begin
            case (mode)
                0:       pat[i] = 1'b0;
                1:       pat[i] = 1'b1;
                2:       pat[i] = (i % 2 == 0);
                3:       pat[i] = (i < 160);
                default: pat[i] = bit'($urandom_range(0, 1));
            endcase
        end
        if (mode == 3) begin
            for (int i = DECIM - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = pat[i]; pat[i] = pat[j]; pat[j] = t;
            end
        end
    endtask

    // One system cycle: apply inputs, advance the reference model, check mic clock
    task automatic tick(input bit r, input bit e);
        bit en_now;
        bit mic_exp;
        int raw, hp;
        exp_t ex;
        rst_in    = r;
        enable_in = e;
        en_now    = !r && e;
        win_done  = 1'b0;
        mic_exp   = (run % CLK_DIV) >= HALF;
        if (en_now && (run % CLK_DIV == 0)) pdm_data_in = pat[nb];
        if (en_now && (run % CLK_DIV == HALF)) begin
            nb++;
            ones += int'(pdm_data_in);
            if (nb == DECIM) begin
                raw    = ones - DECIM / 2;
                ex.due = cyc + 3;
                ex.val = sat8(raw);
                qa.push_back(ex);
                hp     = raw - fdiv(dc_g, 8);
                dc_g   = dc_g + fdiv(raw * 256 - dc_g, 4);
                ex.val = sat8(hp * 4);
                qg.push_back(ex);
                nb = 0; ones = 0; win_done = 1'b1;
            end
        end
        if (!en_now) begin nb = 0; ones = 0; end
        if (r) begin
            while (qa.size() > 0 && qa[$].due > cyc) void'(qa.pop_back());
            while (qg.size() > 0 && qg[$].due > cyc) void'(qg.pop_back());
            dc_g = 0;
        end
        run = en_now ? run + 1 : 0;
        @(negedge clk);
        chk("mic_clk_a", mic_a, mic_exp);
        chk("mic_clk_g", mic_g, mic_exp);
        if (prev_rst) begin
            chk("rst_audio_a", $signed(aa), 0);
            chk("rst_valid_a", va, 0);
            chk("rst_audio_g", $signed(ag), 0);
            chk("rst_valid_g", vg, 0);
        end
        prev_rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int mode);
        gen_pattern(mode);
        tick(1'b0, 1'b1);
        while (!win_done) tick(1'b0, 1'b1);
    endtask

    // Monitor: every strobe must match the oldest expected sample, on its due cycle
    always @(negedge clk) begin
        exp_t ea, eg;
        if (va === 1'b1) begin
            last_strobe = cyc;
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL strobe_a: unexpected strobe value %0d at cycle %0d, expected none", $signed(aa), cyc);
            end else begin
                ea = qa.pop_front();
                chk("audio_a", $signed(aa), ea.val);
                chk("due_a", cyc, ea.due);
                held_a = ea.val;
            end
        end else begin
            chk("hold_a", $signed(aa), held_a);
        end
        if (vg === 1'b1) begin
            if (qg.size() == 0) begin
                checks++; errors++;
                $display("FAIL strobe_g: unexpected strobe value %0d at cycle %0d, expected none", $signed(ag), cyc);
            end else begin
                eg = qg.pop_front();
                chk("audio_g", $signed(ag), eg.val);
                chk("due_g", cyc, eg.due);
                held_g = eg.val;
            end
        end else begin
            chk("hold_g", $signed(ag), held_g);
        end
        if (rst_in) begin held_a = 0; held_g = 0; end
    end

    initial begin
        @(posedge clk);
        #1;
        repeat (3) tick(1'b1, 1'b0);

        // constant ones: saturates high, first strobe latency from enable
        start = cyc;
        run_window(1);
        repeat (3) tick(1'b0, 1'b1);
        chk("first_latency", last_strobe - start, LAT);

        run_window(0);   // constant zeros
        run_window(2);   // alternating
        run_window(3);   // 160 ones per window
        run_window(4);   // random

        // drop enable mid-window: partial window discarded
        gen_pattern(4);
        while (nb < 100) tick(1'b0, 1'b1);
        repeat (5) tick(1'b0, 1'b1);
        repeat (50) tick(1'b0, 1'b0);
        start = cyc;
        run_window(4);
        repeat (3) tick(1'b0, 1'b1);
        chk("reenable_latency", last_strobe - start, LAT);

        // reset in the cycle after a final capture: in-flight sample dropped
        run_window(3);
        tick(1'b1, 1'b1);
        start = cyc;
        run_window(1);
        repeat (3) tick(1'b0, 1'b1);
        chk("post_reset_latency", last_strobe - start, LAT);

        repeat (5) tick(1'b0, 1'b0);
        chk("pending_a", qa.size(), 0);
        chk("pending_g", qg.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pdm_mic_decimator.md
Name: pdm_mic_decimator

Overview:
- Upstream audio source for the recorder stage.
- Drives the PDM microphone clock and captures the 1-bit PDM stream.
- Decimates by boxcar ones-counting, with optional DC removal and gain, and saturates to 8-bit signed PCM.
- Emits one `audio_valid_out` strobe per sample, about 12.2 kHz at 100 MHz. The outputs connect directly to the recorder's `audio_in` / `audio_valid_in`.

Parameters:
- CLK_DIV, 32: system cycles per mic clock period; even, ≥4.
- DECIM, 256: PDM bits per PCM sample; power of two, 16..1024.
- DC_SHIFT, 0: DC-tracking filter shift; 0 disables DC removal, legal 0..12.
- GAIN_SHIFT, 0: arithmetic left shift applied before saturation, 0..4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- enable_in  input  1  run capture; low stops the mic clock and clears the window.
- pdm_data_in  input  1  PDM data from mic, asynchronous to clk_in.
- mic_clk_out  output  1  microphone clock, CLK_DIV-cycle period, 50% duty.
- audio_out  output  8  signed PCM sample, held between strobes.
- audio_valid_out  output  1  single-cycle strobe; audio_out valid in the same cycle.

Behaviour:
- Interface: one clock (clk_in); reset (rst_in) is synchronous and active-high.
- Reset values: mic_clk_out=0, audio_out=0, audio_valid_out=0. Divider, bit counter, ones counter, pipeline and DC state are all 0. All outputs are registered.
- Synchronizer: pdm_data_in passes through a 2-flop synchronizer to produce pdm_sync.
- Mic clock:
  - A divider counts 0..CLK_DIV/2-1 while enable_in=1.
  - mic_clk_out toggles at terminal count.
  - The first high is in cycle CLK_DIV/2, where cycle 0 is the first cycle with rst_in=0 and enable_in=1.
- Capture: pdm_sync is captured in every cycle in which mic_clk_out is driven 0→1 (capture cycle).
- Window:
  - bit_cnt counts 0..DECIM-1.
  - ones_cnt has log2(DECIM)+1 bits.
  - On the capture with bit_cnt=DECIM-1: raw = (ones_cnt + bit) − DECIM/2, signed, log2(DECIM)+1 bits, range −DECIM/2..+DECIM/2.
  - On that same capture, both counters clear.
- Pipeline, 3 stages after the final capture cycle:
  - S1: raw registered.
  - S2: DC removal.
    - DC_SHIFT=0: hp=raw.
    - Otherwise dc is signed, raw width+8 bits fractional: hp = raw − (dc>>>8) using the pre-update dc; dc <= dc + (((raw<<<8) − dc)>>>DC_SHIFT).
  - S3: g = hp<<<GAIN_SHIFT in a width that cannot overflow, then saturate to −128..127 into audio_out. audio_valid_out=1 for exactly this cycle.
- Latency:
  - audio_valid_out is high in capture cycle + 3.
  - First strobe at cycle CLK_DIV/2 + (DECIM−1)·CLK_DIV + 3, which is 8179 for the defaults.
  - Strobes then repeat every DECIM·CLK_DIV cycles (8192).
- No backpressure: the consumer must accept every strobe.
- enable_in falling:
  - On the next cycle, mic_clk_out=0, and the divider, bit_cnt and ones_cnt clear.
  - A partial window is discarded; no strobe is produced for it.
  - Samples already in S1–S3 still complete and strobe.
  - audio_out holds its value; dc state is retained.
- enable_in rising: same timing as after reset (first high at cycle CLK_DIV/2 after the rise).
- rst_in mid-window or mid-pipeline: everything returns to reset values next cycle, and in-flight samples are dropped with no strobe. rst_in has priority over enable_in.
- Saturation boundaries: +DECIM/2 maps to 127 (all-ones window); −DECIM/2 maps to −128.

Test Plan:
- Defaults, pdm_data_in=1 constantly → first audio_valid_out at cycle 8179 with audio_out=127 (saturated from raw=128); next strobe at 8179+8192; mic_clk_out period 32 cycles.
- Defaults, pdm_data_in=0 → audio_out=−128 every strobe. Alternating 1,0 per mic clock → audio_out=0.
- Pattern with 160 ones per 256-bit window → GAIN_SHIFT=0: 32; GAIN_SHIFT=1: 64; GAIN_SHIFT=2: 127 (saturated).
- DC_SHIFT=4, 160 ones per window (raw=32) → first sample 32, magnitude decreasing monotonically; |audio_out| ≤ 1 after 200 samples.
- Deassert enable_in at bit 100 of a window for 50 cycles, then reassert → no strobe for the partial window; mic_clk_out low while disabled; next strobe 8179 cycles after the re-enable.
- Assert rst_in for 1 cycle in the cycle after a final capture → no strobe from the in-flight sample; all outputs 0; the first strobe after release follows the cycle-8179 timing.
